// File: rtl/fpga_prog_pkg.sv
// Shared definitions for the configuration-chain loader: default geometry
// and the loader state encoding.
package fpga_prog_pkg;

   localparam int CHAIN_LEN_DEF = 1480;
   localparam int CLK_DIV_DEF   = 2;
   localparam int CFG_BYTES     = (CHAIN_LEN_DEF + 7) / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SETUP,
      S_HIGH,
      S_FLUSH,
      S_DONE
   } state_t;

endpackage

// File: rtl/prog_clk_gen.sv
// Phase timer for the configuration shift clock: strobes phase_end on the
// last system-clock cycle of each CLK_DIV-long SETUP or HIGH phase.
module prog_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic phase_end
);

   localparam int DW = $clog2(CLK_DIV + 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;

   always_comb begin
      phase_end = run && (div_cnt_q == DW'(CLK_DIV - 1));
      div_cnt_d = div_cnt_q + 1'b1;
      // Restart on every phase boundary so SETUP and HIGH each get a full count
      if (!run || phase_end) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/fpga_prog_loader.sv
// Serialises a byte stream onto the fabric configuration chain while
// capturing the old chain contents from prog_out as a readback byte stream.
module fpga_prog_loader
   import fpga_prog_pkg::*;
#(
   parameter int CHAIN_LEN = CHAIN_LEN_DEF,
   parameter int CLK_DIV   = CLK_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] cfg_data,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   output logic [7:0] rb_data,
   output logic       rb_valid,
   input  logic       rb_ready,
   output logic       prog_in,
   output logic       prog_clk,
   output logic       prog_en,
   input  logic       prog_out,
   output logic       busy,
   output logic       done
);

   localparam int BW = $clog2(CHAIN_LEN + 1);

   state_t        state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [BW-1:0] bit_inc;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    rb_shift_q, rb_shift_d;
   logic [7:0]    rb_data_q, rb_data_d;
   logic          byte_full_q, byte_full_d;
   logic          rb_valid_q, rb_valid_d;
   logic          prog_in_q, prog_in_d;
   logic          prog_clk_q, prog_clk_d;
   logic          prog_en_q, prog_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          run;
   logic          phase_end;

   assign run     = (state_q == S_SETUP) || (state_q == S_HIGH);
   assign bit_inc = bit_cnt_q + 1'b1;

   prog_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .phase_end (phase_end)
   );

   // A pending readback byte blocks the next fetch so readback never overruns
   assign cfg_ready = (state_q == S_FETCH) && !byte_full_q && !rb_valid_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_d      = byte_q;
      byte_full_d = byte_full_q;
      rb_shift_d  = rb_shift_q;
      rb_data_d   = rb_data_q;
      rb_valid_d  = rb_valid_q;
      prog_in_d   = prog_in_q;

      if (rb_valid_q && rb_ready) begin
         rb_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_FETCH;
               bit_cnt_d   = '0;
               rb_shift_d  = '0;
               byte_full_d = 1'b0;
            end
         end
         S_FETCH: begin
            if (cfg_valid && cfg_ready) begin
               byte_d      = cfg_data;
               byte_full_d = 1'b1;
               state_d     = S_SETUP;
            end
         end
         S_SETUP: begin
            // Sample the old chain bit before the rising edge shifts it away
            if (phase_end) begin
               rb_shift_d[bit_cnt_q[2:0]] = prog_out;
               state_d                    = S_HIGH;
            end
         end
         S_HIGH: begin
            if (phase_end) begin
               bit_cnt_d = bit_inc;
               if (bit_inc == BW'(CHAIN_LEN) || bit_inc[2:0] == 3'd0) begin
                  rb_data_d   = rb_shift_q;
                  rb_valid_d  = 1'b1;
                  rb_shift_d  = '0;
                  byte_full_d = 1'b0;
                  state_d     = (bit_inc == BW'(CHAIN_LEN)) ? S_FLUSH : S_FETCH;
               end else begin
                  state_d = S_SETUP;
               end
            end
         end
         S_FLUSH: begin
            if (rb_valid_q && rb_ready) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      prog_clk_d = (state_d == S_HIGH);
      prog_en_d  = (state_d == S_FETCH) || (state_d == S_SETUP) || (state_d == S_HIGH);
      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      if (state_d == S_SETUP) begin
         prog_in_d = byte_d[bit_cnt_d[2:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         byte_q      <= '0;
         byte_full_q <= 1'b0;
         rb_shift_q  <= '0;
         rb_data_q   <= '0;
         rb_valid_q  <= 1'b0;
         prog_in_q   <= 1'b0;
         prog_clk_q  <= 1'b0;
         prog_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_q      <= byte_d;
         byte_full_q <= byte_full_d;
         rb_shift_q  <= rb_shift_d;
         rb_data_q   <= rb_data_d;
         rb_valid_q  <= rb_valid_d;
         prog_in_q   <= prog_in_d;
         prog_clk_q  <= prog_clk_d;
         prog_en_q   <= prog_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rb_data  = rb_data_q;
   assign rb_valid = rb_valid_q;
   assign prog_in  = prog_in_q;
   assign prog_clk = prog_clk_q;
   assign prog_en  = prog_en_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fpga_prog_loader.sv
// Bench for fpga_prog_loader: three loader instances (16/1, 10/1, 1480/2) each
// driving a behavioural fabric chain; readback and shifted-in data are checked.
module tb_fpga_prog_loader;
   import fpga_prog_pkg::*;

   localparam int NI   = 3;
   localparam int LENS [NI] = '{16, 10, 1480};
   localparam int DIVS [NI] = '{1, 1, 2};
   localparam int CAPN = 8192;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n_w     [NI];
   logic       start_w     [NI];
   logic [7:0] cfg_data_w  [NI];
   logic       cfg_valid_w [NI];
   logic       cfg_ready_w [NI];
   logic [7:0] rb_data_w   [NI];
   logic       rb_valid_w  [NI];
   logic       rb_ready_w  [NI];
   logic       prog_in_w   [NI];
   logic       prog_clk_w  [NI];
   logic       prog_en_w   [NI];
   logic       prog_out_w  [NI];
   logic       busy_w      [NI];
   logic       done_w      [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      fpga_prog_loader #(.CHAIN_LEN(LENS[g]), .CLK_DIV(DIVS[g])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n_w[g]),
         .start     (start_w[g]),
         .cfg_data  (cfg_data_w[g]),
         .cfg_valid (cfg_valid_w[g]),
         .cfg_ready (cfg_ready_w[g]),
         .rb_data   (rb_data_w[g]),
         .rb_valid  (rb_valid_w[g]),
         .rb_ready  (rb_ready_w[g]),
         .prog_in   (prog_in_w[g]),
         .prog_clk  (prog_clk_w[g]),
         .prog_en   (prog_en_w[g]),
         .prog_out  (prog_out_w[g]),
         .busy      (busy_w[g]),
         .done      (done_w[g])
      );
   end

   int        vec = 0;
   int        mis = 0;
   bit [7:0]  cfg_buf [256];
   bit [7:0]  rb_got [$];
   bit        pre_bits [NI][1480];
   bit        cap [NI][CAPN];
   int        ecnt [NI];
   bit        prev_clk [NI];
   int        done_cnt;
   bit        timed_out, stall_bad, hold_bad, stab_bad, wh_used, hold_used, aborted;

   // Fabric chain seen as an endless bit stream: the preload followed by
   // every bit ever shifted in; after n rising edges prog_out shows element n.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         prev_clk[k] <= prog_clk_w[k];
         if (prog_clk_w[k] === 1'b1 && !prev_clk[k] && ecnt[k] < CAPN) begin
            cap[k][ecnt[k]] <= prog_in_w[k];
            ecnt[k]         <= ecnt[k] + 1;
         end
      end
   end

   function automatic bit stream_bit(input int k, input int n);
      if (n < LENS[k]) return pre_bits[k][n];
      return cap[k][n - LENS[k]];
   endfunction

   always_comb begin
      for (int k = 0; k < NI; k++) begin
         prog_out_w[k] = stream_bit(k, ecnt[k]);
      end
   end

   function automatic logic [31:0] fab_word(input int k, input int e0, input int n);
      logic [31:0] w = '0;
      for (int i = 0; i < n; i++) w[i] = cap[k][e0 + i];
      return w;
   endfunction

   task automatic run_pass(input int k, input int nb, input int wh_at, input int hold_at,
                           input int abort_at, input bit rbp, output int e0);
      int         in_idx = 0, wh_left = 0, hold_left = 0, e_hold = 0;
      bit         fin = 0, prev_stall = 0;
      logic [7:0] hold_val = '0, prev_rb = '0;
      rb_got.delete();
      done_cnt = 0; timed_out = 0; stall_bad = 0; hold_bad = 0; stab_bad = 0;
      wh_used = 0; hold_used = 0; aborted = 0;
      @(negedge clk);
      e0 = ecnt[k];
      start_w[k] = 1'b1;
      @(negedge clk);
      start_w[k] = 1'b0;
      vec++;
      if (busy_w[k] !== 1'b1 || prog_en_w[k] !== 1'b1) begin
         mis++;
         $display("FAIL start_k%0d: busy=%b prog_en=%b, required 1 1", k, busy_w[k], prog_en_w[k]);
      end
      for (int cyc = 0; cyc < 40000 && !fin; cyc++) begin
         start_w[k] = 1'b0;
         if (done_w[k] === 1'b1) begin
            done_cnt++;
            fin = 1;
         end
         if (abort_at >= 0 && ecnt[k] - e0 >= abort_at) begin
            #2 rst_n_w[k] = 1'b0;
            #1;
            vec++;
            if ({prog_en_w[k], prog_clk_w[k], busy_w[k], cfg_ready_w[k], rb_valid_w[k]} !== 5'b0) begin
               mis++;
               $display("FAIL async_abort_k%0d: en/clk/busy/ready/rbv=%b%b%b%b%b, required 00000", k,
                        prog_en_w[k], prog_clk_w[k], busy_w[k], cfg_ready_w[k], rb_valid_w[k]);
            end
            cfg_valid_w[k] = 1'b0;
            rb_ready_w[k]  = 1'b0;
            aborted = 1;
            repeat (2) @(negedge clk);
            rst_n_w[k] = 1'b1;
            @(negedge clk);
            return;
         end
         if (prev_stall && (rb_valid_w[k] !== 1'b1 || rb_data_w[k] !== prev_rb)) stab_bad = 1;
         if (wh_at >= 0 && !wh_used && in_idx == wh_at && cfg_ready_w[k] === 1'b1) begin
            wh_used = 1;
            wh_left = 20;
         end
         cfg_valid_w[k] = (in_idx < nb) && (wh_left == 0);
         cfg_data_w[k]  = cfg_valid_w[k] ? cfg_buf[in_idx] : 8'($urandom);
         if (wh_left > 0) begin
            if (prog_clk_w[k] !== 1'b0 || prog_en_w[k] !== 1'b1) stall_bad = 1;
            wh_left--;
         end
         if (cfg_valid_w[k] && cfg_ready_w[k] === 1'b1) in_idx++;
         if (hold_at >= 0 && !hold_used && rb_valid_w[k] === 1'b1 && rb_got.size() == hold_at) begin
            hold_used = 1;
            hold_left = 30;
            hold_val  = rb_data_w[k];
            e_hold    = ecnt[k];
            start_w[k] = 1'b1;
         end
         if (hold_left > 0) begin
            rb_ready_w[k] = 1'b0;
            if (cfg_ready_w[k] !== 1'b0 || prog_clk_w[k] !== 1'b0 || rb_valid_w[k] !== 1'b1 ||
                rb_data_w[k] !== hold_val) hold_bad = 1;
            hold_left--;
            if (hold_left == 0 && ecnt[k] != e_hold) hold_bad = 1;
         end else begin
            rb_ready_w[k] = rbp ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (rb_valid_w[k] === 1'b1 && rb_ready_w[k]) rb_got.push_back(rb_data_w[k]);
         prev_stall = (rb_valid_w[k] === 1'b1) && !rb_ready_w[k];
         prev_rb    = rb_data_w[k];
         @(negedge clk);
      end
      cfg_valid_w[k] = 1'b0;
      rb_ready_w[k]  = 1'b0;
      start_w[k]     = 1'b0;
      if (!fin) timed_out = 1;
      repeat (4) begin
         if (done_w[k] === 1'b1) done_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic check_pass(input int k, input int nb, input int e0, input string tag);
      logic [7:0] exp_rb, exp_fab, got_fab;
      vec++;
      if (timed_out) begin
         mis++;
         $display("FAIL %s_timeout: done not seen, required within 40000 cycles", tag);
      end
      vec++;
      if (rb_got.size() != nb) begin
         mis++;
         $display("FAIL %s_rb_count: got %0d bytes, required %0d", tag, rb_got.size(), nb);
      end
      for (int j = 0; j < nb; j++) begin
         exp_rb = '0; exp_fab = '0; got_fab = '0;
         for (int b = 0; b < 8; b++) begin
            if (8 * j + b < LENS[k]) begin
               exp_rb[b]  = stream_bit(k, e0 + 8 * j + b);
               exp_fab[b] = cfg_buf[j][b];
               got_fab[b] = cap[k][e0 + 8 * j + b];
            end
         end
         if (j < rb_got.size()) begin
            vec++;
            if (rb_got[j] !== exp_rb) begin
               mis++;
               $display("FAIL %s_rb[%0d]: got %h, required %h", tag, j, rb_got[j], exp_rb);
            end
         end
         vec++;
         if (got_fab !== exp_fab) begin
            mis++;
            $display("FAIL %s_fabric[%0d]: got %h, required %h", tag, j, got_fab, exp_fab);
         end
      end
      vec++;
      if (ecnt[k] - e0 != LENS[k]) begin
         mis++;
         $display("FAIL %s_edges: got %0d prog_clk rises, required %0d", tag, ecnt[k] - e0, LENS[k]);
      end
      vec++;
      if (done_cnt != 1) begin
         mis++;
         $display("FAIL %s_done: got %0d done cycles, required 1", tag, done_cnt);
      end
      vec++;
      if (stab_bad) begin
         mis++;
         $display("FAIL %s_rb_stable: rb_data/rb_valid changed while stalled, required stable", tag);
      end
      vec++;
      if ({busy_w[k], prog_en_w[k], prog_clk_w[k]} !== 3'b000) begin
         mis++;
         $display("FAIL %s_idle: busy/en/clk=%b%b%b, required 000", tag, busy_w[k], prog_en_w[k], prog_clk_w[k]);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < NI; k++) begin
         rst_n_w[k] = 1'b1; start_w[k] = 1'b0; cfg_valid_w[k] = 1'b0;
         cfg_data_w[k] = '0; rb_ready_w[k] = 1'b0;
      end
      #1;
      for (int k = 0; k < NI; k++) rst_n_w[k] = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         vec++;
         if ({prog_clk_w[k], prog_en_w[k], prog_in_w[k], cfg_ready_w[k], rb_valid_w[k],
              rb_data_w[k], busy_w[k], done_w[k]} !== 15'b0) begin
            mis++;
            $display("FAIL reset_k%0d: clk/en/in/rdy/rbv=%b%b%b%b%b rb_data=%h busy=%b done=%b, required all 0",
                     k, prog_clk_w[k], prog_en_w[k], prog_in_w[k], cfg_ready_w[k], rb_valid_w[k],
                     rb_data_w[k], busy_w[k], done_w[k]);
         end
      end
      for (int k = 0; k < NI; k++) rst_n_w[k] = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic16();
      int e0;
      logic [15:0] got;
      cfg_buf[0] = 8'h34; cfg_buf[1] = 8'h12;
      run_pass(0, 2, -1, -1, -1, 1'b0, e0);
      check_pass(0, 2, e0, "basic16");
      got = (rb_got.size() == 2) ? {rb_got[1], rb_got[0]} : 16'hxxxx;
      vec++;
      if (got !== 16'hBEEF) begin
         mis++;
         $display("FAIL basic16_readback: got %h, required beef", got);
      end
      vec++;
      if (fab_word(0, e0, 16) !== 32'h1234) begin
         mis++;
         $display("FAIL basic16_model: got %h, required 1234", fab_word(0, e0, 16));
      end
   endtask

   task automatic test_cfg_stall();
      int e0;
      cfg_buf[0] = 8'($urandom); cfg_buf[1] = 8'($urandom);
      run_pass(0, 2, 1, -1, -1, 1'b0, e0);
      check_pass(0, 2, e0, "cfg_stall");
      vec++;
      if (!wh_used || stall_bad) begin
         mis++;
         $display("FAIL cfg_stall_hold: stall_seen=%b bad=%b, required 1 0", wh_used, stall_bad);
      end
   endtask

   task automatic test_rb_hold();
      int e0;
      cfg_buf[0] = 8'($urandom); cfg_buf[1] = 8'($urandom);
      run_pass(0, 2, -1, 0, -1, 1'b0, e0);
      check_pass(0, 2, e0, "rb_hold");
      vec++;
      if (!hold_used || hold_bad) begin
         mis++;
         $display("FAIL rb_hold_stall: hold_seen=%b bad=%b, required 1 0", hold_used, hold_bad);
      end
   endtask

   task automatic test_chain10();
      int e0;
      logic [15:0] got;
      cfg_buf[0] = 8'hFF; cfg_buf[1] = 8'h03;
      run_pass(1, 2, -1, -1, -1, 1'b0, e0);
      check_pass(1, 2, e0, "chain10");
      got = (rb_got.size() == 2) ? {rb_got[1], rb_got[0]} : 16'hxxxx;
      vec++;
      if (got !== 16'h02AA) begin
         mis++;
         $display("FAIL chain10_readback: got %h, required 02aa", got);
      end
      vec++;
      if (fab_word(1, e0, 10) !== 32'h3FF) begin
         mis++;
         $display("FAIL chain10_model: got %h, required 3ff", fab_word(1, e0, 10));
      end
      cfg_buf[0] = 8'($urandom); cfg_buf[1] = 8'($urandom);
      run_pass(1, 2, -1, -1, -1, 1'b1, e0);
      check_pass(1, 2, e0, "chain10_rand");
   endtask

   task automatic test_full();
      int e0, bad;
      for (int j = 0; j < CFG_BYTES; j++) cfg_buf[j] = 8'(j);
      run_pass(2, CFG_BYTES, -1, -1, -1, 1'b1, e0);
      check_pass(2, CFG_BYTES, e0, "full1");
      run_pass(2, CFG_BYTES, -1, -1, -1, 1'b1, e0);
      check_pass(2, CFG_BYTES, e0, "full2");
      bad = 0;
      for (int j = 0; j < CFG_BYTES; j++) begin
         if (j >= rb_got.size() || rb_got[j] !== 8'(j)) bad++;
      end
      vec++;
      if (bad != 0) begin
         mis++;
         $display("FAIL full2_readback: %0d bytes differ from pass-1 input, required 0", bad);
      end
   endtask

   task automatic test_reset_midpass();
      int e0;
      for (int j = 0; j < CFG_BYTES; j++) cfg_buf[j] = 8'($urandom);
      run_pass(2, CFG_BYTES, -1, -1, 700, 1'b0, e0);
      vec++;
      if (!aborted) begin
         mis++;
         $display("FAIL midpass_abort: abort point not reached, required bit 700");
      end
      for (int j = 0; j < CFG_BYTES; j++) cfg_buf[j] = 8'($urandom);
      run_pass(2, CFG_BYTES, -1, -1, -1, 1'b1, e0);
      check_pass(2, CFG_BYTES, e0, "after_abort");
   endtask

   initial begin
      for (int i = 0; i < 16; i++) pre_bits[0][i] = (16'hBEEF >> i) & 1;
      for (int i = 0; i < 10; i++) pre_bits[1][i] = (10'h2AA >> i) & 1;
      for (int i = 0; i < 1480; i++) pre_bits[2][i] = 1'($urandom);
      test_reset();
      test_basic16();
      test_cfg_stall();
      test_rb_hold();
      test_chain10();
      test_full();
      test_reset_midpass();
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
